stopwatch_time_ctrl: RTL

Sequencer for the stopwatch time-keeping datapath. Consumes the level-mode controls produced by the front-panel button controller (run mode, clear-on, display mode). Owns a STOP/RUN/CLEAR state machine, a clock prescaler, and a cascaded centisecond/second/minute/hour counter chain. Drives registered digit-pair values to the 7-segment display path.

---
 rtl/stopwatch_time_ctrl_if.sv | 57 +++++
 rtl/stopwatch_time_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_ctrl_if.sv
// Control/status bundle between the front-panel button controller, the
// stopwatch sequencer and the 7-segment display path.
//
//   run_md   : run mode level (1 = run, 0 = stop)
//   clr_on   : clear request level, high while the clear button is held
//   disp_md  : display select (0 = hr:min, 1 = sec:cs)
//   cs/sec/min/hr     : current time fields
//   disp_hi/disp_lo   : registered digit-pair values for the display
//   tick/rollover     : one-cycle event pulses
//   state             : sequencer state (0 = STOP, 1 = RUN, 2 = CLEAR)
//
// master : the side that drives the controls and observes the time
// slave  : the stopwatch sequencer itself
interface stopwatch_time_ctrl_if;
  logic       run_md;
  logic       clr_on;
  logic       disp_md;
  logic [6:0] cs;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [6:0] disp_hi;
  logic [6:0] disp_lo;
  logic       tick;
  logic       rollover;
  logic [1:0] state;

  modport master (
    output run_md,
    output clr_on,
    output disp_md,
    input  cs,
    input  sec,
    input  min,
    input  hr,
    input  disp_hi,
    input  disp_lo,
    input  tick,
    input  rollover,
    input  state
  );

  modport slave (
    input  run_md,
    input  clr_on,
    input  disp_md,
    output cs,
    output sec,
    output min,
    output hr,
    output disp_hi,
    output disp_lo,
    output tick,
    output rollover,
    output state
  );
endinterface

// File: rtl/stopwatch_time_ctrl.sv
// Stopwatch time-keeping sequencer.
//
// A STOP/RUN/CLEAR state machine gates a clock prescaler that produces one
// centisecond tick every PRESCALE clocks. Each tick advances a cascaded
// cs/sec/min/hr counter chain (all carries resolved in a single edge). The
// selected digit pairs are registered for the 7-segment display path.
//
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : stopwatch_time_ctrl_if.slave (controls in, time/status out)
//
// Parameters:
//   PRESCALE : clk cycles per centisecond tick, >= 2
//   PS_W     : prescaler width, 2**PS_W >= PRESCALE
module stopwatch_time_ctrl #(
  parameter int unsigned PRESCALE = 1000000,
  parameter int unsigned PS_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StRun   = 2'd1,
    StClear = 2'd2
  } state_e;

  localparam logic [PS_W-1:0] PsMax = PS_W'(PRESCALE - 1);

  localparam logic [6:0] CsMax  = 7'd99;
  localparam logic [5:0] SecMax = 6'd59;
  localparam logic [5:0] MinMax = 6'd59;
  localparam logic [4:0] HrMax  = 5'd23;

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [6:0]      cs_q, cs_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hr_q, hr_d;
  logic [6:0]      disp_hi_q, disp_hi_d;
  logic [6:0]      disp_lo_q, disp_lo_d;
  logic            tick_q, tick_d;
  logic            rollover_q, rollover_d;

  logic clear_now;
  logic run_now;
  logic wrap;
  logic all_max;

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStop: begin
        // run_md wins over clr_on when both are requested
        if (bus.run_md) begin
          state_d = StRun;
        end else if (bus.clr_on) begin
          state_d = StClear;
        end
      end
      StRun: begin
        if (!bus.run_md) begin
          state_d = StStop;
        end
      end
      StClear: begin
        if (!bus.clr_on) begin
          state_d = bus.run_md ? StRun : StStop;
        end
      end
      // Unused encoding 2'd3 falls back to STOP
      default: state_d = StStop;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStop;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and counter chain
  // ---------------------------------------------------------------------------
  // Clearing covers the entry edge into CLEAR as well as every cycle spent in
  // it. Counting uses the pre-edge state, so a tick on the same edge that
  // leaves RUN still lands.
  assign clear_now = (state_q == StClear) || (state_d == StClear);
  assign run_now   = (state_q == StRun);
  assign wrap      = run_now && (ps_q == PsMax);
  assign all_max   = (cs_q == CsMax) && (sec_q == SecMax) &&
                     (min_q == MinMax) && (hr_q == HrMax);

  always_comb begin
    ps_d       = ps_q;
    cs_d       = cs_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    tick_d     = 1'b0;
    rollover_d = 1'b0;

    if (clear_now) begin
      ps_d  = '0;
      cs_d  = '0;
      sec_d = '0;
      min_d = '0;
      hr_d  = '0;
    end else if (run_now) begin
      if (wrap) begin
        ps_d       = '0;
        tick_d     = 1'b1;
        rollover_d = all_max;
        // Full carry ripple in one edge so no partial value is ever visible
        if (cs_q == CsMax) begin
          cs_d = '0;
          if (sec_q == SecMax) begin
            sec_d = '0;
            if (min_q == MinMax) begin
              min_d = '0;
              if (hr_q == HrMax) begin
                hr_d = '0;
              end else begin
                hr_d = hr_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          cs_d = cs_q + 7'd1;
        end
      end else begin
        ps_d = ps_q + {{(PS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display select, taken from the post-update counter values
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_hi_d = '0;
    disp_lo_d = '0;
    if (bus.disp_md) begin
      disp_hi_d = {1'b0, sec_d};
      disp_lo_d = cs_d;
    end else begin
      disp_hi_d = {2'b00, hr_d};
      disp_lo_d = {1'b0, min_d};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q       <= '0;
      cs_q       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      disp_hi_q  <= '0;
      disp_lo_q  <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      cs_q       <= cs_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      disp_hi_q  <= disp_hi_d;
      disp_lo_q  <= disp_lo_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cs       = cs_q;
  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hr       = hr_q;
  assign bus.disp_hi  = disp_hi_q;
  assign bus.disp_lo  = disp_lo_q;
  assign bus.tick     = tick_q;
  assign bus.rollover = rollover_q;
  assign bus.state    = state_q;

endmodule
